// File: rtl/cache_ctrl_top.sv
// cache_ctrl_top: 4-way set-associative read cache controller with an external line-fill port.
// Reads run through two registered stages: stage 1 snapshots the indexed set at acceptance,
// stage 2 compares tags, selects the word and registers the response. Misses never allocate.
// Optional hit/miss performance counters are compiled in with CACHE_CTRL_PERF_EN.
module cache_ctrl_top #(
  parameter int unsigned SETS = 128,
  parameter int unsigned WAYS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill_en,
  input  logic [31:0]  fill_addr,
  input  logic [127:0] fill_data,
  input  logic [3:0]   fill_meta,
  input  logic         inv_all,
  input  logic         uvld,
  input  logic [31:0]  uaddr,
  output logic         urdy,
`ifdef CACHE_CTRL_PERF_EN
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
`endif
  output logic         resp_vld,
  output logic [31:0]  resp_data,
  output logic         resp_hit,
  output logic [3:0]   resp_meta,
  input  logic         resp_rdy
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = 30 - IdxW;
  localparam int unsigned WayW = $clog2(WAYS);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [TagW-1:0] tag_t;

  // Line storage; deliberately not reset so lines survive rst (only inv_all clears valid).
  tag_t            tag_q   [SETS][WAYS];
  logic [127:0]    data_q  [SETS][WAYS];
  logic [3:0]      meta_q  [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];

  // Fill address split and victim choice
  idx_t            f_idx;
  tag_t            f_tag;
  logic [WayW-1:0] f_way;
  logic            f_found;
  logic            unused_fill_off;

  assign f_idx           = fill_addr[IdxW+1:2];
  assign f_tag           = fill_addr[31:IdxW+2];
  assign unused_fill_off = ^fill_addr[1:0];

  // Victim: first invalid way, else the way already holding this tag, else way 0.
  always_comb begin
    f_way   = '0;
    f_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!f_found && !valid_q[f_idx][w]) begin
        f_way   = WayW'(w);
        f_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!f_found && (tag_q[f_idx][w] == f_tag)) begin
        f_way   = WayW'(w);
        f_found = 1'b1;
      end
    end
  end

  // Array write port: bulk invalidate first, then a fill claims its way (fill wins on overlap).
  always_ff @(posedge clk) begin
    if (inv_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end
    if (fill_en) begin
      valid_q[f_idx][f_way] <= 1'b1;
      tag_q[f_idx][f_way]   <= f_tag;
      data_q[f_idx][f_way]  <= fill_data;
      meta_q[f_idx][f_way]  <= fill_meta;
    end
  end

  // Read request split and handshake
  idx_t r_idx;
  tag_t r_tag;
  logic rdy_en_q;
  logic advance;
  logic accept;

  logic            s1_vld_q, s1_vld_d;
  tag_t            s1_tag_q;
  tag_t            s1_wtag_q [WAYS];
  logic [WAYS-1:0] s1_wvld_q;
  logic [31:0]     s1_word_q [WAYS];
  logic [3:0]      s1_meta_q [WAYS];

  logic        resp_vld_q, resp_vld_d;
  logic        resp_hit_q, resp_hit_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [3:0]  resp_meta_q, resp_meta_d;

  logic        cmp_hit;
  logic [31:0] cmp_data;
  logic [3:0]  cmp_meta;

  assign r_idx   = uaddr[IdxW+1:2];
  assign r_tag   = uaddr[31:IdxW+2];
  // Stage 2 can take new data when empty or when its response is leaving this cycle.
  assign advance = !resp_vld_q || resp_rdy;
  assign urdy    = rdy_en_q && (!s1_vld_q || advance);
  assign accept  = uvld && urdy;

  // Ready enable: held low asynchronously by rst, rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Stage 1: snapshot the indexed set at acceptance so later fills cannot disturb this read.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_tag_q <= r_tag;
      for (int w = 0; w < WAYS; w++) begin
        s1_wtag_q[w] <= tag_q[r_idx][w];
        s1_wvld_q[w] <= valid_q[r_idx][w];
        s1_word_q[w] <= data_q[r_idx][w][{uaddr[1:0], 5'd0} +: 32];
        s1_meta_q[w] <= meta_q[r_idx][w];
      end
    end
  end

  // Stage 1 occupancy: filled by an accept, emptied when stage 2 takes it.
  always_comb begin
    s1_vld_d = s1_vld_q;
    if (advance) begin
      s1_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d = 1'b1;
    end
  end

  // Stage 2 compare: lowest matching valid way wins; a miss yields all-zero data and meta.
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_data = '0;
    cmp_meta = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (s1_wvld_q[w] && (s1_wtag_q[w] == s1_tag_q)) begin
        cmp_hit  = 1'b1;
        cmp_data = s1_word_q[w];
        cmp_meta = s1_meta_q[w];
      end
    end
  end

  // Response register next state: hold while stalled, otherwise load from stage 1.
  always_comb begin
    resp_vld_d  = resp_vld_q;
    resp_hit_d  = resp_hit_q;
    resp_data_d = resp_data_q;
    resp_meta_d = resp_meta_q;
    if (advance) begin
      resp_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        resp_hit_d  = cmp_hit;
        resp_data_d = cmp_data;
        resp_meta_d = cmp_meta;
      end
    end
  end

  // Pipeline control state; rst drops every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      resp_meta_q <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      resp_vld_q  <= resp_vld_d;
      resp_hit_q  <= resp_hit_d;
      resp_data_q <= resp_data_d;
      resp_meta_q <= resp_meta_d;
    end
  end

  assign resp_vld  = resp_vld_q;
  assign resp_hit  = resp_hit_q;
  assign resp_data = resp_data_q;
  assign resp_meta = resp_meta_q;

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        consume;

  assign consume = resp_vld_q && resp_rdy;

  // Saturating hit/miss counters, stepped once per consumed response.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (consume) begin
      if (resp_hit_q) begin
        if (hit_cnt_q != '1) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end
      end else begin
        if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
    end
  end

  // Counter registers, cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_top.sv
// Bench for cache_ctrl_top: a set/way cache model plus an ordered expectation queue checked
// every cycle, and literal expectations for the directed read sequences.
module tb_cache_ctrl_top;

  localparam int unsigned SETS = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fill_en = 1'b0;
  logic [31:0]  fill_addr = '0;
  logic [127:0] fill_data = '0;
  logic [3:0]   fill_meta = '0;
  logic         inv_all = 1'b0;
  logic         uvld = 1'b0;
  logic [31:0]  uaddr = '0;
  logic         urdy;
  logic         resp_vld;
  logic [31:0]  resp_data;
  logic         resp_hit;
  logic [3:0]   resp_meta;
  logic         resp_rdy = 1'b1;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  cache_ctrl_top #(.SETS(SETS), .WAYS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .fill_meta (fill_meta),
    .inv_all   (inv_all),
    .uvld      (uvld),
    .uaddr     (uaddr),
    .urdy      (urdy),
`ifdef CACHE_CTRL_PERF_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .resp_vld  (resp_vld),
    .resp_data (resp_data),
    .resp_hit  (resp_hit),
    .resp_meta (resp_meta),
    .resp_rdy  (resp_rdy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache model: per set, four ways of {valid, tag, line, meta}
  bit           m_vld  [SETS][4];
  int unsigned  m_tag  [SETS][4];
  logic [127:0] m_data [SETS][4];
  logic [3:0]   m_meta [SETS][4];

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic [3:0]  meta;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] lg_data[$];
  logic        lg_hit[$];
  logic [3:0]  lg_meta[$];
  int          m_hits = 0;
  int          m_miss = 0;
  int          cyc = 0;
  bit          prev_rst = 1'b1;
  logic        exp_vld;
  logic        exp_urdy;

  function automatic void m_fill(input logic [31:0] a, input logic [127:0] d, input logic [3:0] m);
    int unsigned line = a >> 2;
    int unsigned s = line % SETS;
    int unsigned t = line / SETS;
    int v = -1;
    for (int w = 0; w < 4; w++) if (v < 0 && !m_vld[s][w]) v = w;
    for (int w = 0; w < 4; w++) if (v < 0 && m_tag[s][w] == t) v = w;
    if (v < 0) v = 0;
    m_vld[s][v]  = 1'b1;
    m_tag[s][v]  = t;
    m_data[s][v] = d;
    m_meta[s][v] = m;
  endfunction

  function automatic exp_t m_look(input logic [31:0] a, input int acc);
    int unsigned line = a >> 2;
    int unsigned s = line % SETS;
    int unsigned t = line / SETS;
    int unsigned off = a % 4;
    exp_t e;
    e.hit = 1'b0; e.data = '0; e.meta = '0; e.acc = acc;
    for (int w = 3; w >= 0; w--) begin
      if (m_vld[s][w] && m_tag[s][w] == t) begin
        e.hit  = 1'b1;
        e.data = 32'(m_data[s][w] >> (32 * off));
        e.meta = m_meta[s][w];
      end
    end
    return e;
  endfunction

  // Per-cycle compare: sample between edges; lookups see the arrays before this edge's writes.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_resp_vld", resp_vld, 1'b0);
      chk("rst_urdy", urdy, 1'b0);
      q.delete();
      m_hits = 0;
      m_miss = 0;
      prev_rst = 1'b1;
    end else begin
      exp_vld = (q.size() > 0) && (q[0].acc <= cyc - 2);
      chk("resp_vld", resp_vld, exp_vld);
      if (resp_vld && exp_vld) begin
        chk("resp_data", resp_data, q[0].data);
        chk("resp_hit", resp_hit, q[0].hit);
        chk("resp_meta", resp_meta, q[0].meta);
      end
      exp_urdy = !prev_rst && !((q.size() == 2) && !resp_rdy);
      chk("urdy", urdy, exp_urdy);
      if (resp_vld && resp_rdy && q.size() > 0) begin
        lg_data.push_back(resp_data);
        lg_hit.push_back(resp_hit);
        lg_meta.push_back(resp_meta);
        if (q[0].hit) m_hits++; else m_miss++;
        void'(q.pop_front());
      end
      if (uvld && urdy) q.push_back(m_look(uaddr, cyc));
      prev_rst = 1'b0;
    end
    if (inv_all) begin
      for (int s = 0; s < SETS; s++) for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
    end
    if (fill_en) m_fill(fill_addr, fill_data, fill_meta);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [127:0] d, input logic [3:0] m);
    fill_en = 1'b1; fill_addr = a; fill_data = d; fill_meta = m;
    step();
    fill_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    int n = 0;
    logic acc = 1'b0;
    uvld = 1'b1;
    uaddr = a;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = urdy;
      step();
      n++;
    end
    uvld = 1'b0;
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    step();
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_hit.delete(); lg_meta.delete();
  endtask

  localparam logic [31:0] LA = 32'h0FF001F0;
  localparam logic [31:0] LB = 32'h0AA001F0;
  localparam logic [31:0] LC = 32'h0BB001F0;
  localparam logic [31:0] LD = 32'h000001F0;
  localparam logic [31:0] LE = 32'h0DD001F0;
  localparam logic [31:0] LF = 32'h12345670;

  localparam logic [127:0] DA = {32'h00FF00FF, 32'h00FFFF00, 32'hF0F0F0F0, 32'hFF0000FF};
  localparam logic [127:0] DB = {32'hEEFFEEFF, 32'h00000000, 32'hAAAAAAAA, 32'h11111111};
  localparam logic [127:0] DC = {32'h00000000, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h33333333};
  localparam logic [127:0] DD = {32'h11111111, 32'hF0F0F0F0, 32'h10000001, 32'h11110000};
  localparam logic [127:0] DE = {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};
  localparam logic [127:0] DF = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};
  localparam logic [127:0] DB2 = {32'h0B0B0003, 32'h0B0B0002, 32'h0B0B0001, 32'hCAFE0000};

  logic [31:0] base [4] = '{LA, LB, LC, LD};
  logic [31:0] exp28 [16] = '{
    32'hFF0000FF, 32'h11111111, 32'h33333333, 32'h11110000,
    32'hF0F0F0F0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h10000001,
    32'h00FFFF00, 32'h00000000, 32'hAAAAAAAA, 32'hF0F0F0F0,
    32'h00FF00FF, 32'hEEFFEEFF, 32'h00000000, 32'h11111111
  };

  logic urdy_low;
  int   n_before;

  initial begin
    step();
    // Clear valid bits, then load lines while still in reset.
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    fill(LA, DA, 4'b1101);
    fill(LB, DB, 4'b0010);
    fill(LC, DC, 4'b0111);
    fill(LD, DD, 4'b1010);
    fill(LF, DF, 4'b0110);
    rst = 1'b0;
    step();

    // 16 back-to-back reads, offsets interleaved across the four lines.
    clear_log();
    for (int i = 0; i < 16; i++) send(base[i % 4] + 32'(i / 4));
    drain();
    chk("seq_count", lg_data.size(), 16);
    for (int i = 0; i < 16 && i < lg_data.size(); i++) begin
      chk($sformatf("seq_data%0d", i), lg_data[i], exp28[i]);
      chk($sformatf("seq_hit%0d", i), lg_hit[i], 1'b1);
    end
    if (lg_meta.size() > 0) chk("seq_meta_A", lg_meta[0], 4'b1101);

    // Miss on an absent tag; hit in another set.
    clear_log();
    send(32'h0CC001F0);
    send(LF + 32'd3);
    drain();
    chk("miss_count", lg_data.size(), 2);
    if (lg_data.size() == 2) begin
      chk("miss_hit", lg_hit[0], 1'b0);
      chk("miss_data", lg_data[0], 32'h0);
      chk("miss_meta", lg_meta[0], 4'h0);
      chk("setF_data", lg_data[1], 32'hF3F3F3F3);
      chk("setF_meta", lg_meta[1], 4'b0110);
    end

    // Single read latency.
    uvld = 1'b1; uaddr = LA;
    @(negedge clk);
    chk("lat_urdy", urdy, 1'b1);
    step();
    uvld = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", resp_vld, 1'b0);
    @(negedge clk);
    chk("lat_cycle2", resp_vld, 1'b1);
    chk("lat_meta", resp_meta, 4'b1101);
    chk("lat_data", resp_data, 32'hFF0000FF);
    step();
    drain();

    // Downstream stall for 5 cycles during a stream.
    clear_log();
    urdy_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(base[i % 4] + 32'(i / 4));
      end
      begin
        repeat (3) step();
        resp_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!urdy) urdy_low = 1'b1;
          step();
        end
        resp_rdy = 1'b1;
      end
    join
    drain();
    chk("stall_urdy_dropped", urdy_low, 1'b1);
    chk("stall_count", lg_data.size(), 8);
    for (int i = 0; i < 8 && i < lg_data.size(); i++) begin
      chk($sformatf("stall_data%0d", i), lg_data[i], exp28[i]);
    end

    // Fill to the set of an in-flight read; only later reads see it.
    clear_log();
    send(LB);
    fill(LB, DB2, 4'h5);
    send(LB);
    drain();
    chk("raw_count", lg_data.size(), 2);
    if (lg_data.size() == 2) begin
      chk("raw_old", lg_data[0], 32'h11111111);
      chk("raw_new", lg_data[1], 32'hCAFE0000);
      chk("raw_new_meta", lg_meta[1], 4'h5);
    end

    // Full set, new tag: way 0 (line A) is replaced.
    clear_log();
    fill(LE, DE, 4'h9);
    send(LA);
    send(LE + 32'd2);
    send(LC + 32'd1);
    drain();
    chk("evict_count", lg_data.size(), 3);
    if (lg_data.size() == 3) begin
      chk("evict_A_hit", lg_hit[0], 1'b0);
      chk("evict_E_data", lg_data[1], 32'hEEEE0002);
      chk("evict_C_data", lg_data[2], 32'hBBBBBBBB);
    end

    // Reset mid-stream drops in-flight reads.
    for (int i = 0; i < 6; i++) begin
      uvld = 1'b1;
      uaddr = base[i % 4];
      if (i == 3) begin
        rst = 1'b1;
        n_before = lg_data.size();
        #1;
        chk("rst_vld_now", resp_vld, 1'b0);
      end
      step();
    end
    uvld = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();
    chk("no_resp_after_rst", lg_data.size(), n_before);

    // Arrays survive reset; then bulk invalidate makes everything miss.
    clear_log();
    fill(LA, DA, 4'b1101);
    send(LC + 32'd1);
    send(LA);
    drain();
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    send(LA);
    send(LC + 32'd1);
    drain();
    chk("inv_count", lg_data.size(), 4);
    if (lg_data.size() == 4) begin
      chk("post_rst_C", lg_data[0], 32'hBBBBBBBB);
      chk("refill_A", lg_data[1], 32'hFF0000FF);
      chk("inv_A_hit", lg_hit[2], 1'b0);
      chk("inv_C_hit", lg_hit[3], 1'b0);
      chk("inv_C_data", lg_data[3], 32'h0);
    end

`ifdef CACHE_CTRL_PERF_EN
    chk("hit_cnt", hit_cnt, 32'(m_hits));
    chk("miss_cnt", miss_cnt, 32'(m_miss));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_top.md
CACHE_CTRL_TOP -- requirements
Module: cache_ctrl_top

Interface
REQ-001 SHALL have parameter SETS, default 128, number of sets (power of two, 2..1024).
REQ-002 SHALL have parameter WAYS, default 4, associativity; only 4 is supported.
REQ-003 SHALL have port clk  in  1  the single clock; all flops sample on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have ports fill_en/fill_addr/fill_data/fill_meta  in  1/32/128/4  line fill: word address, words {w3,w2,w1,w0}, opaque 4-bit line metadata.
REQ-006 SHALL have port inv_all  in  1  synchronous clear of all valid bits.
REQ-007 SHALL have ports uvld/uaddr  in  1/32  read request valid and word address; urdy  out  1  request ready.
REQ-008 SHALL have ports resp_vld/resp_data/resp_hit/resp_meta  out  1/32/1/4  response; resp_rdy  in  1  downstream ready.

Function
REQ-009 Address split SHALL be: offset = uaddr[1:0] (word in line), index = next log2(SETS) bits, tag = remaining upper bits.
REQ-010 A fill SHALL write tag, the 4 data words, fill_meta, and set valid, in the first way of the indexed set whose valid is 0 (way 0 first), else in the way whose tag matches, else in way 0.
REQ-011 Fill SHALL take effect at the clock edge where fill_en=1, including while rst=1.
REQ-012 A request SHALL be accepted on a clock edge where uvld&&urdy.
REQ-013 Lookup SHALL compare the tag against all 4 valid ways in parallel; hit SHALL return the selected word of the matching way.
REQ-014 A miss SHALL return resp_hit=0, resp_data=0, resp_meta=0, with no allocation and no refill.
REQ-015 Response for an accepted request SHALL assert resp_vld exactly 2 cycles after acceptance when unstalled (stage 1: array read, stage 2: compare/select/register).
REQ-016 Responses SHALL be returned in request order; a response is consumed on the edge where resp_vld&&resp_rdy.
REQ-017 Sustained throughput SHALL be one request per cycle when resp_rdy=1.
REQ-018 With resp_vld=1 and resp_rdy=0, the pipeline SHALL stall: resp_data/resp_hit/resp_meta held stable, urdy deasserted when no free stage remains, with no loss or duplication.
REQ-019 urdy SHALL be 0 while rst=1.
REQ-020 A fill to the same set as an in-flight read SHALL NOT alter that read's returned data; reads accepted on later edges SHALL see the fill.
REQ-021 inv_all SHALL clear all valid bits at the edge; reads already in stage 2 complete with their looked-up result.

Reset
REQ-022 rst SHALL asynchronously clear pipeline valid flags, resp_vld=0, resp_hit=0, resp_data=0, resp_meta=0, urdy=0, and any counters.
REQ-023 rst SHALL NOT clear tag, data, metadata or valid arrays; clearing them is done only with inv_all.
REQ-024 Reset mid-operation SHALL drop all in-flight requests without producing responses.
REQ-025 After rst falls, urdy SHALL be 1 from the next rising edge.

Configuration
REQ-026 With macro CACHE_CTRL_PERF_EN defined, the block SHALL add outputs hit_cnt and miss_cnt (32 bits each), incremented per response consumed, saturating at all-ones, cleared by rst.
REQ-027 Without CACHE_CTRL_PERF_EN these ports and counters SHALL be absent; function is otherwise identical.

Verification
REQ-028 Fill set 0x7C with tags of 0x0FF001F0, 0x0AA001F0, 0x0BB001F0, 0x000001F0, data words w0 = FF0000FF, 11111111, 33333333, 11110000 respectively, during rst; release; 16 back-to-back reads, offsets 0..3 interleaved across the four lines -> responses in order FF0000FF, 11111111, 33333333, 11110000, F0F0F0F0, AAAAAAAA, BBBBBBBB, 10000001, 00FFFF00, 00000000, AAAAAAAA, F0F0F0F0, 00FF00FF, EEFFEEFF, 00000000, 11111111, all with resp_hit=1.
REQ-029 Read 0x0CC001F0 after that fill -> resp_hit=0, resp_data=0.
REQ-030 Hold resp_rdy=0 for 5 cycles during a stream of reads -> urdy drops, held response stable, no response lost once released.
REQ-031 Single read -> resp_vld exactly 2 cycles after acceptance; resp_meta equals the line's fill_meta (e.g. 4'b1101 for the 0x0FF001F0 line).
REQ-032 inv_all then re-read 0x0FF001F0 -> miss; assert rst mid-stream -> no further responses, resp_vld=0 immediately.
